// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR period monitor: FSM state encoding,
// error codes reported on err_code, and the default lock-up bit pattern.
// No ports (package).
// -----------------------------------------------------------------------------
package lfsr_pkg;

  // FSM state encoding, 3 bits
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ARM  = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_FAIL = 3'd4;

  // err_code values
  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_LOCK   = 2'b01;
  localparam logic [1:0] ERR_REPEAT = 2'b10;

  // Default lock-up word is all-zero (XOR-tap LFSR); replicated to WIDTH
  // by the user of the package. An XNOR-tap LFSR locks at all-ones instead.
  localparam logic LOCK_BIT_DFLT = 1'b0;

endpackage : lfsr_pkg

// File: rtl/lfsr_period_monitor_if.sv
// -----------------------------------------------------------------------------
// lfsr_period_monitor_if
// Groups the sample stream and the result signals of the period monitor.
//   master : drives start/valid/data_in, observes results (bench / LFSR side)
//   slave  : the monitor itself
// Signals:
//   start    pulse, clear results and arm capture
//   valid    data_in holds a new LFSR sample
//   data_in  WIDTH-bit LFSR sample
//   busy     monitor in ARM or RUN
//   done     period measured (level, sticky)
//   fail     check aborted (level, sticky)
//   err_code 00 none, 01 lock-up, 10 repeat
//   period   WIDTH+1 bit measured period
//   maximal  done and period == 2^WIDTH-1
// -----------------------------------------------------------------------------
interface lfsr_period_monitor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             valid;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic             fail;
  logic [1:0]       err_code;
  logic [WIDTH:0]   period;
  logic             maximal;

  modport master (
    output start, valid, data_in,
    input  busy, done, fail, err_code, period, maximal
  );

  modport slave (
    input  start, valid, data_in,
    output busy, done, fail, err_code, period, maximal
  );
endinterface : lfsr_period_monitor_if

// File: rtl/lfsr_seen_bitmap.sv
// -----------------------------------------------------------------------------
// lfsr_seen_bitmap
// One flag per possible LFSR word, recording which words have appeared since
// the last clear.
// Ports:
//   clk        rising-edge clock
//   i_clr      synchronous clear of all flags (wins over i_set)
//   i_set      set flag i_set_idx
//   i_set_idx  index of flag to set
//   i_q_idx    lookup index
//   o_q_hit    flag at i_q_idx (combinational lookup of registered flags)
// -----------------------------------------------------------------------------
module lfsr_seen_bitmap #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_set,
  input  logic [WIDTH-1:0] i_set_idx,
  input  logic [WIDTH-1:0] i_q_idx,
  output logic             o_q_hit
);

  logic [(2**WIDTH)-1:0] r_seen;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_seen <= '0;
    end else if (i_set) begin
      r_seen[i_set_idx] <= 1'b1;
    end
  end

  assign o_q_hit = r_seen[i_q_idx];

endmodule : lfsr_seen_bitmap

// File: rtl/lfsr_period_monitor.sv
// -----------------------------------------------------------------------------
// lfsr_period_monitor
// Checks an LFSR output stream: captures the first sample after start as a
// reference and counts samples until it recurs, reporting the period and
// whether it is maximal. Aborts with an error code when the lock-up word
// appears or when a word other than the reference repeats.
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high; returns to IDLE and zeroes all outputs
//   mon_if  slave side of lfsr_period_monitor_if (stream in, results out)
// -----------------------------------------------------------------------------
module lfsr_period_monitor
  import lfsr_pkg::*;
#(
  parameter int             WIDTH    = 4,
  parameter logic [WIDTH-1:0] LOCK_VAL = {WIDTH{LOCK_BIT_DFLT}}
) (
  input  logic                  clk,
  input  logic                  reset,
  lfsr_period_monitor_if.slave  mon_if
);

  localparam logic [WIDTH:0] MAX_PER = {1'b0, {WIDTH{1'b1}}};

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;

  logic [WIDTH-1:0] r_ref;
  logic [WIDTH:0]   r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_fail;
  logic [1:0]       r_err;
  logic [WIDTH:0]   r_period;
  logic             r_maximal;

  logic [WIDTH-1:0] w_ref_nxt;
  logic [WIDTH:0]   w_count_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_fail_nxt;
  logic [1:0]       w_err_nxt;
  logic [WIDTH:0]   w_period_nxt;
  logic             w_maximal_nxt;

  logic             w_is_lock;
  logic             w_is_ref;
  logic             w_hit;
  logic             w_set;
  logic             w_clr;

  assign w_is_lock = (mon_if.data_in == LOCK_VAL);
  assign w_is_ref  = (mon_if.data_in == r_ref);
  // start clears the history on the same edge it re-arms the FSM
  assign w_clr     = reset | mon_if.start;

  lfsr_seen_bitmap #(
    .WIDTH (WIDTH)
  ) u_seen (
    .clk       (clk),
    .i_clr     (w_clr),
    .i_set     (w_set),
    .i_set_idx (mon_if.data_in),
    .i_q_idx   (mon_if.data_in),
    .o_q_hit   (w_hit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start overrides everything, including a same-cycle sample
  always_comb begin
    w_state_nxt = r_state;
    if (mon_if.start) begin
      w_state_nxt = ST_ARM;
    end else if (mon_if.valid) begin
      case (r_state)
        ST_ARM: begin
          w_state_nxt = w_is_lock ? ST_FAIL : ST_RUN;
        end
        ST_RUN: begin
          if (w_is_ref) begin
            w_state_nxt = ST_DONE;
          end else if (w_is_lock || w_hit) begin
            w_state_nxt = ST_FAIL;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Output / datapath next values; everything holds unless a sample decides
  always_comb begin
    w_ref_nxt     = r_ref;
    w_count_nxt   = r_count;
    w_done_nxt    = r_done;
    w_fail_nxt    = r_fail;
    w_err_nxt     = r_err;
    w_period_nxt  = r_period;
    w_maximal_nxt = r_maximal;
    w_set         = 1'b0;
    if (mon_if.start) begin
      w_count_nxt   = '0;
      w_done_nxt    = 1'b0;
      w_fail_nxt    = 1'b0;
      w_err_nxt     = ERR_NONE;
      w_period_nxt  = '0;
      w_maximal_nxt = 1'b0;
    end else if (mon_if.valid) begin
      case (r_state)
        ST_ARM: begin
          if (w_is_lock) begin
            w_fail_nxt = 1'b1;
            w_err_nxt  = ERR_LOCK;
          end else begin
            w_ref_nxt   = mon_if.data_in;
            w_set       = 1'b1;
            w_count_nxt = {{WIDTH{1'b0}}, 1'b1};
          end
        end
        ST_RUN: begin
          // Reference match is checked first so a clean full cycle is never
          // misreported as a repeat (the reference is also in the bitmap).
          if (w_is_ref) begin
            w_done_nxt    = 1'b1;
            w_period_nxt  = r_count;
            w_maximal_nxt = (r_count == MAX_PER);
          end else if (w_is_lock) begin
            w_fail_nxt = 1'b1;
            w_err_nxt  = ERR_LOCK;
          end else if (w_hit) begin
            w_fail_nxt = 1'b1;
            w_err_nxt  = ERR_REPEAT;
          end else begin
            w_set       = 1'b1;
            w_count_nxt = r_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
    w_busy_nxt = (w_state_nxt == ST_ARM) || (w_state_nxt == ST_RUN);
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ref     <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_fail    <= 1'b0;
      r_err     <= ERR_NONE;
      r_period  <= '0;
      r_maximal <= 1'b0;
    end else begin
      r_ref     <= w_ref_nxt;
      r_count   <= w_count_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_fail    <= w_fail_nxt;
      r_err     <= w_err_nxt;
      r_period  <= w_period_nxt;
      r_maximal <= w_maximal_nxt;
    end
  end

  assign mon_if.busy     = r_busy;
  assign mon_if.done     = r_done;
  assign mon_if.fail     = r_fail;
  assign mon_if.err_code = r_err;
  assign mon_if.period   = r_period;
  assign mon_if.maximal  = r_maximal;

endmodule : lfsr_period_monitor

// File: tb/tb_lfsr_period_monitor.sv
// -----------------------------------------------------------------------------
// tb_lfsr_period_monitor
// Directed stimulus for lfsr_period_monitor. Each scenario that ends in a
// result pushes its expected result onto a queue; a monitor process pops and
// compares whenever done or fail rises.
// -----------------------------------------------------------------------------
module tb_lfsr_period_monitor;
  import lfsr_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  lfsr_period_monitor_if #(.WIDTH(4)) bus ();

  lfsr_period_monitor #(
    .WIDTH    (4),
    .LOCK_VAL (4'b0000)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .mon_if (bus)
  );

  typedef struct {
    logic       done;
    logic       fail;
    logic [1:0] err;
    logic [4:0] period;
    logic       maximal;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic d, input logic f, input logic [1:0] e,
                      input logic [4:0] p, input logic m);
    exp_t x;
    x.done = d; x.fail = f; x.err = e; x.period = p; x.maximal = m;
    sb.push_back(x);
  endtask

  // Inputs change on the falling edge; the DUT samples them on the next rising edge.
  task automatic drive(input logic s, input logic v, input logic [3:0] d);
    @(negedge clk);
    bus.start   = s;
    bus.valid   = v;
    bus.data_in = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0);
  endtask

  task automatic stream(input logic [3:0] v0, input logic [3:0] v1,
                        input logic [3:0] v2, input logic [3:0] v3);
    drive(1'b0, 1'b1, v0);
    drive(1'b0, 1'b1, v1);
    drive(1'b0, 1'b1, v2);
    drive(1'b0, 1'b1, v3);
  endtask

  // Result monitor
  initial begin : monitor
    logic prev_term;
    logic term;
    exp_t e;
    prev_term = 1'b0;
    forever begin
      @(negedge clk);
      term = bus.done | bus.fail;
      if (term && !prev_term) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done",     int'(bus.done),     int'(e.done));
          check("fail",     int'(bus.fail),     int'(e.fail));
          check("err_code", int'(bus.err_code), int'(e.err));
          check("period",   int'(bus.period),   int'(e.period));
          check("maximal",  int'(bus.maximal),  int'(e.maximal));
          check("busy_end", int'(bus.busy),     0);
        end
      end
      prev_term = term;
    end
  end

  initial begin : stim
    logic [3:0] s;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.valid   = 1'b0;
    bus.data_in = 4'h0;
    @(negedge clk);
    check("rst_busy",    int'(bus.busy),     0);
    check("rst_done",    int'(bus.done),     0);
    check("rst_fail",    int'(bus.fail),     0);
    check("rst_err",     int'(bus.err_code), 0);
    check("rst_period",  int'(bus.period),   0);
    check("rst_maximal", int'(bus.maximal),  0);
    reset = 1'b0;
    idle(2);

    // Full x^4+x^3+1 sequence seeded 1111: 16th sample returns to the seed
    push(1'b1, 1'b0, ERR_NONE, 5'd15, 1'b1);
    drive(1'b1, 1'b0, 4'h0);
    s = 4'hF;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, s);
      s = {s[2:0], s[3] ^ s[2]};
    end
    idle(3);

    // Short cycle closing on the reference
    push(1'b1, 1'b0, ERR_NONE, 5'd3, 1'b0);
    drive(1'b1, 1'b0, 4'h0);
    stream(4'd1, 4'd2, 4'd3, 4'd1);
    idle(2);
    // DONE is sticky: further samples change nothing
    drive(1'b0, 1'b1, 4'd2);
    drive(1'b0, 1'b1, 4'd0);
    idle(1);
    check("sticky_done",   int'(bus.done),   1);
    check("sticky_period", int'(bus.period), 3);
    check("sticky_fail",   int'(bus.fail),   0);

    // Lock-up as first sample
    push(1'b0, 1'b1, ERR_LOCK, 5'd0, 1'b0);
    drive(1'b1, 1'b0, 4'h0);
    drive(1'b0, 1'b1, 4'd0);
    idle(3);

    // Lock-up in RUN
    push(1'b0, 1'b1, ERR_LOCK, 5'd0, 1'b0);
    drive(1'b1, 1'b0, 4'h0);
    drive(1'b0, 1'b1, 4'd5);
    drive(1'b0, 1'b1, 4'd9);
    drive(1'b0, 1'b1, 4'd0);
    idle(3);

    // Non-reference word repeats
    push(1'b0, 1'b1, ERR_REPEAT, 5'd0, 1'b0);
    drive(1'b1, 1'b0, 4'h0);
    stream(4'd1, 4'd2, 4'd3, 4'd2);
    idle(3);

    // Short cycle with three idle cycles after each sample
    push(1'b1, 1'b0, ERR_NONE, 5'd3, 1'b0);
    drive(1'b1, 1'b0, 4'h0);
    idle(1);
    check("gap_busy_armed", int'(bus.busy), 1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 4'(k + 1));
      idle(3);
      check("gap_busy", int'(bus.busy), 1);
      check("gap_done", int'(bus.done), 0);
    end
    drive(1'b0, 1'b1, 4'd1);
    idle(3);

    // Reset after six samples aborts with no result
    drive(1'b1, 1'b0, 4'h0);
    s = 4'hF;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, s);
      s = {s[2:0], s[3] ^ s[2]};
    end
    idle(1);
    check("mid_busy", int'(bus.busy), 1);
    @(negedge clk);
    reset     = 1'b1;
    bus.valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy",    int'(bus.busy),     0);
    check("abort_done",    int'(bus.done),     0);
    check("abort_fail",    int'(bus.fail),     0);
    check("abort_err",     int'(bus.err_code), 0);
    check("abort_period",  int'(bus.period),   0);
    check("abort_maximal", int'(bus.maximal),  0);
    // IDLE ignores samples
    drive(1'b0, 1'b1, 4'd3);
    drive(1'b0, 1'b1, 4'd3);
    idle(1);
    check("idle_busy", int'(bus.busy), 0);
    check("idle_done", int'(bus.done), 0);
    check("idle_fail", int'(bus.fail), 0);

    // start mid-RUN re-arms; the sample alongside start is ignored
    push(1'b1, 1'b0, ERR_NONE, 5'd2, 1'b0);
    drive(1'b1, 1'b0, 4'h0);
    drive(1'b0, 1'b1, 4'd1);
    drive(1'b0, 1'b1, 4'd2);
    drive(1'b0, 1'b1, 4'd3);
    drive(1'b1, 1'b1, 4'd7);
    drive(1'b0, 1'b1, 4'd4);
    drive(1'b0, 1'b1, 4'd5);
    drive(1'b0, 1'b1, 4'd4);
    idle(3);

    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("results_pending", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_lfsr_period_monitor
